core_debug_cmd_bridge: RTL

CORE_DEBUG_CMD_BRIDGE -- requirements
Module: core_debug_cmd_bridge

---
 rtl/core_debug_cmd_bridge_pkg.sv | 32 +++
 rtl/core_debug_cmd_bridge_if.sv | 30 +++
 rtl/core_debug_cmd_bridge_timeout.sv | 33 +++
 rtl/core_debug_cmd_bridge.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/core_debug_cmd_bridge_pkg.sv
// Shared definitions for the host-to-debug-core command bridge: state encoding,
// packet header marker, response status codes and the debug core's command set.
package core_debug_cmd_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_TGT,
        RX_DATA,
        ISSUE,
        WAIT_RESP,
        TX
    } bridgeStateT;

    localparam logic [3:0] HDR_MARKER     = 4'hA;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_ERROR   = 8'h01;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

    localparam logic [3:0] CMD_READ       = 4'h0;
    localparam logic [3:0] CMD_WRITE      = 4'h8;
    localparam logic [3:0] CMD_CONTROL    = 4'hF;

    localparam logic [1:0] RX_LAST_BYTE   = 2'd3;
    localparam logic [2:0] TX_LAST_BYTE   = 3'd4;

    // Only these commands are forwarded; anything else is answered locally with an error.
    function automatic logic isIssuedCmd(input logic [3:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_CONTROL);
    endfunction

endpackage

// File: rtl/core_debug_cmd_bridge_if.sv
// Bundle of the host byte streams and the debug-core command/response port.
// master = bridge side, slave = host/debug-core side.
interface core_debug_cmd_bridge_if;

    logic        iRX_VALID;
    logic [7:0]  iRX_DATA;
    logic        oRX_BUSY;
    logic        oTX_VALID;
    logic [7:0]  oTX_DATA;
    logic        iTX_BUSY;
    logic        oCMD_REQ;
    logic        iCMD_BUSY;
    logic [3:0]  oCMD_COMMAND;
    logic [7:0]  oCMD_TARGET;
    logic [31:0] oCMD_DATA;
    logic        iRESP_VALID;
    logic        iRESP_ERROR;
    logic [31:0] iRESP_DATA;

    modport master (
        input  iRX_VALID, iRX_DATA, iTX_BUSY, iCMD_BUSY, iRESP_VALID, iRESP_ERROR, iRESP_DATA,
        output oRX_BUSY, oTX_VALID, oTX_DATA, oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA
    );

    modport slave (
        output iRX_VALID, iRX_DATA, iTX_BUSY, iCMD_BUSY, iRESP_VALID, iRESP_ERROR, iRESP_DATA,
        input  oRX_BUSY, oTX_VALID, oTX_DATA, oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA
    );

endinterface

// File: rtl/core_debug_cmd_bridge_timeout.sv
// Response-wait watchdog for the command bridge; exists only when
// PROCESSOR_DEBUG_CMD_TIMEOUT_EN is defined.
`ifdef PROCESSOR_DEBUG_CMD_TIMEOUT_EN
module core_debug_cmd_bridge_timeout #(
    parameter int P_TIMEOUT_CYCLES = 1024
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iClear,
    input  logic iCount,
    output logic oExpired
);

    localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(P_TIMEOUT_CYCLES - 1);

    logic [CW-1:0] waitCount;

    // Counts completed wait cycles; holds at the limit so it can never wrap.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            waitCount <= '0;
        end else if (iClear) begin
            waitCount <= '0;
        end else if (iCount && (waitCount != LAST_CYCLE)) begin
            waitCount <= waitCount + 1'b1;
        end
    end

    assign oExpired = iCount && (waitCount == LAST_CYCLE);

endmodule
`endif

// File: rtl/core_debug_cmd_bridge.sv
// Host byte-stream to debug-core command bridge: parses A<cmd> tgt d0..d3 packets,
// issues the command, returns status + 32-bit data. Optional wait timeout: PROCESSOR_DEBUG_CMD_TIMEOUT_EN.
module core_debug_cmd_bridge
    import core_debug_cmd_bridge_pkg::*;
#(
    parameter int P_TIMEOUT_CYCLES = 1024
) (
    input  logic iCLOCK,
    input  logic inRESET,
    core_debug_cmd_bridge_if.master bus
);

    bridgeStateT state;
    bridgeStateT stateNext;

    logic [3:0]  command;
    logic [7:0]  target;
    logic [31:0] cmdData;
    logic [7:0]  status;
    logic [31:0] respData;
    logic [1:0]  rxCount;
    logic [2:0]  txCount;

    logic        rxBusy;
    logic        txValid;
    logic        cmdReq;
    logic [7:0]  txByte;
    logic        rxFire;
    logic        txFire;
    logic        cmdAccept;

`ifdef PROCESSOR_DEBUG_CMD_TIMEOUT_EN
    logic timeoutHit;

    core_debug_cmd_bridge_timeout #(
        .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)
    ) uTimeout (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iClear  (cmdAccept),
        .iCount  (state == WAIT_RESP),
        .oExpired(timeoutHit)
    );
`endif

    assign rxFire    = bus.iRX_VALID && !rxBusy;
    assign txFire    = txValid && !bus.iTX_BUSY;
    assign cmdAccept = cmdReq && !bus.iCMD_BUSY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Non-header bytes in IDLE are dropped so the host can resync on the next 0xA? byte.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (rxFire && (bus.iRX_DATA[7:4] == HDR_MARKER)) stateNext = RX_TGT;
            RX_TGT:    if (rxFire) stateNext = RX_DATA;
            RX_DATA:   if (rxFire && (rxCount == RX_LAST_BYTE))
                           stateNext = isIssuedCmd(command) ? ISSUE : TX;
            ISSUE:     if (cmdAccept) stateNext = WAIT_RESP;
            WAIT_RESP: begin
                if (bus.iRESP_VALID) begin
                    stateNext = TX;
                end
`ifdef PROCESSOR_DEBUG_CMD_TIMEOUT_EN
                else if (timeoutHit) begin
                    stateNext = TX;
                end
`endif
            end
            TX:        if (txFire && (txCount == TX_LAST_BYTE)) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_comb begin
        rxBusy  = 1'b1;
        txValid = 1'b0;
        cmdReq  = 1'b0;
        txByte  = 8'h00;
        case (state)
            IDLE, RX_TGT, RX_DATA: rxBusy = 1'b0;
            ISSUE:                 cmdReq = 1'b1;
            TX: begin
                txValid = 1'b1;
                case (txCount)
                    3'd0:    txByte = status;
                    3'd1:    txByte = respData[7:0];
                    3'd2:    txByte = respData[15:8];
                    3'd3:    txByte = respData[23:16];
                    3'd4:    txByte = respData[31:24];
                    default: txByte = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // Command fields change only while receiving, so they stay stable through ISSUE..TX.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            command  <= '0;
            target   <= '0;
            cmdData  <= '0;
            status   <= '0;
            respData <= '0;
            rxCount  <= '0;
            txCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxFire && (bus.iRX_DATA[7:4] == HDR_MARKER)) begin
                        command <= bus.iRX_DATA[3:0];
                    end
                end
                RX_TGT: begin
                    if (rxFire) begin
                        target  <= bus.iRX_DATA;
                        rxCount <= '0;
                    end
                end
                RX_DATA: begin
                    if (rxFire) begin
                        cmdData[{rxCount, 3'b000} +: 8] <= bus.iRX_DATA;
                        rxCount <= rxCount + 2'd1;
                        if ((rxCount == RX_LAST_BYTE) && !isIssuedCmd(command)) begin
                            status   <= STATUS_ERROR;
                            respData <= '0;
                            txCount  <= '0;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (bus.iRESP_VALID) begin
                        status   <= bus.iRESP_ERROR ? STATUS_ERROR : STATUS_OK;
                        respData <= bus.iRESP_DATA;
                        txCount  <= '0;
                    end
`ifdef PROCESSOR_DEBUG_CMD_TIMEOUT_EN
                    else if (timeoutHit) begin
                        status   <= STATUS_TIMEOUT;
                        respData <= '0;
                        txCount  <= '0;
                    end
`endif
                end
                TX: begin
                    if (txFire) begin
                        txCount <= (txCount == TX_LAST_BYTE) ? 3'd0 : txCount + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oRX_BUSY     = rxBusy;
    assign bus.oTX_VALID    = txValid;
    assign bus.oTX_DATA     = txByte;
    assign bus.oCMD_REQ     = cmdReq;
    assign bus.oCMD_COMMAND = command;
    assign bus.oCMD_TARGET  = target;
    assign bus.oCMD_DATA    = cmdData;

endmodule
